tri_record_assembler: RTL and testbench
=======================================

# tri_record_assembler

Parametrised successor to the fixed six-word texel assembler. It consumes a framed stream of bus words and packs each group of `WORDS_PER_REC` words into one record. Completed records go into an internal record FIFO of `REC_DEPTH` entries, and the FIFO hands them downstream over a valid/ready handshake. The block sits between the AHB slave read buffer and the rasteriser front end, and keeps running while the consumer is still busy with earlier records.

## Interface

Parameters:
- `WORD_W`, 32, input word width
- `WORDS_PER_REC`, 6, words per record (≥2)
- `REC_DEPTH`, 2, record FIFO depth (≥1)
- `CNT_W`, 16, width of the per-frame record counter
- `FRAME_START`, 32'd0, frame-open marker
- `FRAME_END`, 32'd1, frame-close marker

Ports (one clock `clk`; reset `n_rst` is synchronous and active-low):
- `clk` in 1: clock, rising edge
- `n_rst` in 1: synchronous active-low reset
- `flush` in 1: synchronous abort; empties the FIFO and returns the FSM to IDLE
- `in_data` in `WORD_W`: head word of the AHB buffer
- `in_valid` in 1: `in_data` is valid
- `in_read` out 1: pop request; a word is consumed when `in_valid && in_read`
- `rec_data` out `WORD_W*WORDS_PER_REC`: FIFO head record; word k occupies bits [k*WORD_W +: WORD_W]
- `rec_valid` out 1: FIFO not empty
- `rec_ready` in 1: consumer accepts the head record
- `frame_active` out 1: the FSM is inside a frame (COLLECT or BOUND)
- `frame_done` out 1: one-cycle pulse, the cycle after `FRAME_END` is consumed
- `tri_count` out `CNT_W`: records pushed in the current or last frame, saturating

## Operation

States: IDLE, COLLECT, BOUND. Word index `idx` runs 0..WORDS_PER_REC-1.

- **IDLE:**
  - `in_read`=1.
  - A consumed word equal to `FRAME_START` moves the FSM to COLLECT, with `idx`←0 and `tri_count`←0.
  - Any other consumed word is discarded.
- **COLLECT:**
  - `in_read`=1, except when `idx`=last and the FIFO is full; then `in_read`=0.
  - Each consumed word is stored at `idx` in the assembly register.
  - On the last word, {word, assembly words} is pushed as one record, `tri_count` increments (saturating at all-ones), and the FSM moves to BOUND.
  - Marker values are ordinary data in COLLECT.
- **BOUND:**
  - `in_read`=1.
  - A consumed `FRAME_END` moves the FSM to IDLE and pulses `frame_done` on the next cycle.
  - Any other word, including `FRAME_START`, becomes word 0 of the next record; the FSM moves to COLLECT with `idx`←1. There is no bubble between records.
- **Record FIFO:**
  - Pop occurs on `rec_valid && rec_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - `rec_data` is 0 when the FIFO is empty.
- **Flush:**
  - The FIFO count goes to 0, the FSM goes to IDLE and `idx`←0.
  - `tri_count` holds its value. No `frame_done` pulse is produced.
  - `n_rst` has priority over `flush`.
- **`in_read`** is a function of state, `idx` and the registered FIFO count only. It never depends on `in_valid`.

## Timing

- **Reset values:**
  - `in_read`=1 (IDLE)
  - `rec_valid`=0
  - `rec_data`=0
  - `frame_active`=0
  - `frame_done`=0
  - `tri_count`=0
  - FIFO empty
- **Latency:** last word consumed in cycle N → `rec_valid`=1 in N+1.
- **Throughput:** one word per cycle while `in_valid`=1 and the FIFO has space.
- **Full FIFO with the last word pending:**
  - `in_read`=0 until the count drops below `REC_DEPTH`.
  - A pop in cycle N re-enables `in_read` in N+1. This is a registered-count decision; there is no same-cycle bypass.
- **`frame_active`** follows the registered state.
- **`tri_count`** updates in the cycle after the push.
- **Reset or flush mid-record:** the partial record is lost and no push occurs. A record already in the FIFO is lost on flush.

## Structure

- The following go in `defines_package.vh`:
  - the `tra_state_t` enum {IDLE, COLLECT, BOUND}
  - default `FRAME_START`/`FRAME_END` constants
  - the `WORD_W` default
- Sub-module `rec_fifo`: a synchronous FIFO parametrised by width and depth. It provides push, pop, count, full and empty; its storage is registers; reset is synchronous active-low with a flush input.
- The top level holds the FSM, `idx`, the assembly register and `tri_count`.

## Test plan

- **Single frame, one record, defaults:** input 0, A1..A6, 1 with `rec_ready`=1 → `rec_valid` for one cycle with word0=A1 and word5=A6; `frame_done` pulses; `tri_count`=1.
- **Back-to-back records:** input 0, twelve words, 1 → two records with no idle input cycle; `tri_count`=2. A `FRAME_START` value (0) in word 0 of the second record is stored as data.
- **Backpressure:** `rec_ready`=0, three records, `REC_DEPTH`=2 → `in_read` drops on the last word of record 3. Raising `rec_ready` for one cycle restores `in_read` the next cycle and record 3 completes.
- **Garbage in IDLE:** words 5, 7, then a frame → 5 and 7 are consumed and discarded; no record is pushed.
- **Flush mid-record:** `flush` after 3 words, with one record queued → `rec_valid`=0 next cycle, FSM in IDLE; a new frame assembles correctly.
- **Saturation and reset:** `CNT_W`=2 with 5 records → `tri_count`=3. `n_rst`=0 mid-record → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/tri_record_assembler_pkg.sv
// Shared types and defaults for the record assembler.
// Holds the FSM state enum and the default frame markers and word width.
package tri_record_assembler_pkg;

  localparam int TRA_WORD_W = 32;

  localparam logic [31:0] TRA_FRAME_START = 32'd0;
  localparam logic [31:0] TRA_FRAME_END   = 32'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    BOUND   = 2'd2
  } tra_state_t;

endpackage

// File: rtl/tri_record_assembler_fifo.sv
// rec_fifo: register-based synchronous FIFO with flush.
// Ports: push_i/push_data_i write, pop_i/pop_data_o read (0 when empty),
// count_o/full_o/empty_o status; n_rst_i sync active-low, flush_i clears.
module rec_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          n_rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (!n_rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/tri_record_assembler.sv
// Packs framed bus words into WORDS_PER_REC-word records and queues them.
// Ports: in_* word input with pop request, rec_* record valid/ready output,
// frame_active/frame_done/tri_count status; n_rst sync active-low, flush abort.
module tri_record_assembler
  import tri_record_assembler_pkg::*;
#(
  parameter int WORD_W        = TRA_WORD_W,
  parameter int WORDS_PER_REC = 6,
  parameter int REC_DEPTH     = 2,
  parameter int CNT_W         = 16,
  parameter logic [WORD_W-1:0] FRAME_START = WORD_W'(TRA_FRAME_START),
  parameter logic [WORD_W-1:0] FRAME_END   = WORD_W'(TRA_FRAME_END)
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            flush,
  input  logic [WORD_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_read,
  output logic [WORD_W*WORDS_PER_REC-1:0] rec_data,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic                            frame_active,
  output logic                            frame_done,
  output logic [CNT_W-1:0]                tri_count
);

  localparam int REC_W  = WORD_W * WORDS_PER_REC;
  localparam int ASM_W  = WORD_W * (WORDS_PER_REC - 1);
  localparam int IDX_W  = $clog2(WORDS_PER_REC);
  localparam int FCNT_W = $clog2(REC_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_REC - 1);

  tra_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt_unused;
  logic              fire;
  logic              push;
  logic [REC_W-1:0]  push_rec;

  // Stall only when the record about to complete has nowhere to go.
  assign in_read  = !(state_q == COLLECT && idx_q == LAST && fifo_full);
  assign fire     = in_valid && in_read;
  assign push     = fire && state_q == COLLECT && idx_q == LAST;
  assign push_rec = {in_data, asm_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire && in_data == FRAME_START) begin
          state_d = COLLECT;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (fire) begin
          if (idx_q == LAST) begin
            state_d = BOUND;
            idx_d   = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            for (int k = 0; k < WORDS_PER_REC - 1; k++)
              if (idx_q == IDX_W'(k))
                asm_d[k*WORD_W +: WORD_W] = in_data;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      BOUND: begin
        if (fire) begin
          if (in_data == FRAME_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Non-marker word opens the next record without a bubble.
            asm_d[0 +: WORD_W] = in_data;
            idx_d   = IDX_W'(1);
            state_d = COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  rec_fifo #(
    .W     (REC_W),
    .DEPTH (REC_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .n_rst_i     (n_rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_rec),
    .pop_i       (rec_ready),
    .pop_data_o  (rec_data),
    .count_o     (fifo_cnt_unused),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rec_valid    = !fifo_empty;
  assign frame_active = (state_q != IDLE);
  assign frame_done   = done_q;
  assign tri_count    = cnt_q;

endmodule

// File: tb/tb_tri_record_assembler.sv
// Scoreboard bench for tri_record_assembler with a queue-based frame model.
// Directed scenarios first, then randomized frames with random backpressure.
module tb_tri_record_assembler;

  localparam int W    = 32;
  localparam int N    = 6;
  localparam int D    = 2;
  localparam int C    = 2;
  localparam int RW   = W * N;
  localparam int MAXC = (1 << C) - 1;
  localparam logic [W-1:0] START = 32'd0;
  localparam logic [W-1:0] ENDW  = 32'd1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_read;
  logic [RW-1:0] rec_data;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic          frame_active;
  logic          frame_done;
  logic [C-1:0]  tri_count;

  always #5 clk = ~clk;

  tri_record_assembler #(
    .WORD_W        (W),
    .WORDS_PER_REC (N),
    .REC_DEPTH     (D),
    .CNT_W         (C),
    .FRAME_START   (START),
    .FRAME_END     (ENDW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_read      (in_read),
    .rec_data     (rec_data),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .tri_count    (tri_count)
  );

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0;
  bit gap_en = 1'b0;

  // Reference model: words of the record being built, queued records,
  // whether a frame is open and whether we sit right after a record.
  logic [W-1:0]  cur[$];
  logic [RW-1:0] sb[$];
  bit            m_frame = 1'b0;
  bit            m_bound = 1'b0;
  bit            m_done = 1'b0;
  int            m_cnt = 0;

  task automatic check(input string nm, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic consume(input logic [W-1:0] w);
    logic [RW-1:0] r;
    if (!m_frame) begin
      if (w == START) begin
        m_frame = 1'b1;
        m_bound = 1'b0;
        m_cnt = 0;
        cur.delete();
      end
    end else if (m_bound && w == ENDW) begin
      m_frame = 1'b0;
      m_bound = 1'b0;
      m_done = 1'b1;
    end else begin
      m_bound = 1'b0;
      cur.push_back(w);
      if (cur.size() == N) begin
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = cur[k];
        sb.push_back(r);
        cur.delete();
        m_cnt++;
        m_bound = 1'b1;
      end
    end
  endtask

  // Monitor: compare at the falling edge, then advance the model
  // across the coming rising edge using the inputs now stable.
  initial begin
    bit exp_rd;
    int exp_cnt;
    forever begin
      @(negedge clk);
      exp_rd = !(m_frame && cur.size() == N - 1 && sb.size() == D);
      exp_cnt = (m_cnt > MAXC) ? MAXC : m_cnt;
      if (chk_en) begin
        check("in_read", RW'(in_read), RW'(exp_rd));
        check("rec_valid", RW'(rec_valid), RW'(sb.size() != 0));
        check("rec_data", rec_data, (sb.size() != 0) ? sb[0] : '0);
        check("frame_active", RW'(frame_active), RW'(m_frame));
        check("frame_done", RW'(frame_done), RW'(m_done));
        check("tri_count", RW'(tri_count), RW'(exp_cnt));
      end
      m_done = 1'b0;
      if (!n_rst) begin
        sb.delete();
        cur.delete();
        m_frame = 1'b0;
        m_bound = 1'b0;
        m_cnt = 0;
      end else if (flush) begin
        sb.delete();
        cur.delete();
        m_frame = 1'b0;
        m_bound = 1'b0;
      end else begin
        if (sb.size() != 0 && rec_ready) void'(sb.pop_front());
        if (in_valid && exp_rd) consume(in_data);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rec_ready = 1'b0;
      1:       rec_ready = 1'b1;
      default: rec_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    int t;
    bit ok;
    if (gap_en && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    in_data = w;
    in_valid = 1'b1;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = in_read;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout got=stalled exp=consumed word=%h", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  function automatic logic [W-1:0] rword();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return START;
    if (r == 1) return ENDW;
    return $urandom;
  endfunction

  initial begin
    int nrec;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    rdy_mode = 1;
    idle(2);

    // single record
    send(START);
    for (int k = 1; k <= N; k++) send(32'hA000_0000 + k);
    send(ENDW);
    idle(4);

    // back-to-back, START value as word 0 of record 2
    send(START);
    for (int k = 0; k < 2 * N; k++)
      send((k == N) ? START : 32'hB000_0000 + k);
    send(ENDW);
    idle(4);

    // garbage in IDLE, then a frame
    send(32'd5);
    send(32'd7);
    idle(2);
    send(START);
    for (int k = 0; k < N; k++) send(32'hC000_0000 + k);
    send(ENDW);
    idle(4);

    // backpressure: third record stalls until one pop
    rdy_mode = 0;
    fork
      begin
        send(START);
        for (int k = 0; k < 3 * N; k++) send(32'hD000_0000 + k);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    send(ENDW);
    idle(3);
    rdy_mode = 1;
    idle(6);

    // flush mid-record with one record queued
    rdy_mode = 0;
    send(START);
    for (int k = 0; k < N + 3; k++) send(32'hE000_0000 + k);
    idle(2);
    pulse_flush();
    idle(2);
    rdy_mode = 1;
    send(START);
    for (int k = 0; k < N; k++) send(32'hF000_0000 + k);
    send(ENDW);
    idle(4);

    // counter saturation with five records
    send(START);
    for (int k = 0; k < 5 * N; k++) send(32'h1100_0000 + k);
    send(ENDW);
    idle(4);

    // reset mid-record
    send(START);
    for (int k = 0; k < 3; k++) send(32'h2200_0000 + k);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(2);
    send(START);
    for (int k = 0; k < N; k++) send(32'h3300_0000 + k);
    send(ENDW);
    idle(4);

    // randomized frames
    rdy_mode = 2;
    gap_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) send(rword());
      send(START);
      nrec = $urandom_range(1, 3);
      for (int k = 0; k < nrec * N; k++) send(rword());
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, N - 1)); k++)
          send(rword());
        pulse_flush();
      end else begin
        send(ENDW);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end

    rdy_mode = 1;
    gap_en = 1'b0;
    idle(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
